fire4_5_expand3_ofm_writer: RTL and testbench

Downstream output stage for the shared fire4/fire5 expand-3×3 engine. On each sample strobe it captures the engine's 128-channel output vector, then serializes it into the layer's output feature-map RAM, one 16-bit word per cycle. After all 32×32 pixels are written, it raises the RAM-feedback pulse the engine uses to drop its finish flag.

---
 rtl/fire_pkg.sv | 31 +++
 rtl/ofm_capture_buf.sv | 37 +++
 rtl/fire4_5_expand3_ofm_writer.sv | 184 ++++++++++++++++++
 tb/tb_fire4_5_expand3_ofm_writer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fire_pkg.sv
// -----------------------------------------------------------------------------
// fire_pkg
// Shared definitions for the fire4/fire5 expand-3x3 output stage:
//   - writer FSM state encoding
//   - activation width and per-layer geometry (channels per pixel, map side)
//   - RAM word-address width derivation
// -----------------------------------------------------------------------------
package fire_pkg;

    // Writer FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_e;

    // Activation word width
    localparam int FIRE45_WIDTH  = 16;
    // Channels per output pixel (engine MAC count)
    localparam int FIRE45_DSP_NO = 128;
    // Output feature-map side (pixels per layer = side squared)
    localparam int FIRE45_WOUT   = 32;

    // Word-address width needed to hold every channel of every pixel
    function automatic int calc_addr_w(input int wout, input int dsp_no);
        return $clog2(wout * wout * dsp_no);
    endfunction

    localparam int FIRE45_ADDR_W = calc_addr_w(FIRE45_WOUT, FIRE45_DSP_NO);

endpackage

// File: rtl/ofm_capture_buf.sv
// -----------------------------------------------------------------------------
// ofm_capture_buf
// Holds one captured output pixel (DSP_NO channels of WIDTH bits) while the
// writer serializes it into the feature-map RAM.
// Ports:
//   clk        rising-edge clock
//   load_i     copy data_i into the buffer at this edge
//   data_i     DSP_NO x WIDTH channel vector from the engine
//   rd_idx_i   channel to present on rd_data_o
//   rd_data_o  combinational read of the selected channel
// The contents are deliberately not reset: every word is overwritten by a
// load before it can be read out.
// -----------------------------------------------------------------------------
module ofm_capture_buf #(
    parameter int  WIDTH  = 16,
    parameter int  DSP_NO = 128,
    localparam int CH_W   = $clog2(DSP_NO)
) (
    input  logic             clk,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i [0:DSP_NO-1],
    input  logic [CH_W-1:0]  rd_idx_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] buf_q [0:DSP_NO-1];

    // Capture the whole channel vector on a load strobe
    always_ff @(posedge clk) begin
        if (load_i) begin
            buf_q <= data_i;
        end
    end

    assign rd_data_o = buf_q[rd_idx_i];

endmodule

// File: rtl/fire4_5_expand3_ofm_writer.sv
// -----------------------------------------------------------------------------
// fire4_5_expand3_ofm_writer
// Output stage of the shared fire4/fire5 expand-3x3 engine. A sample strobe
// captures the 128-channel output vector; the vector is then written into the
// output feature-map RAM one word per cycle, pixel-major / channel-minor.
// After the last word of the last pixel, a one-cycle feedback pulse tells the
// engine the layer is complete.
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-low reset
//   start_i         layer start pulse: clears counters and overflow, aborts
//   sample_i        ofm_i valid strobe
//   ofm_i           DSP_NO x WIDTH post-ReLU channel outputs
//   ram_we_o        RAM write enable
//   ram_addr_o      RAM word address (0 when not writing)
//   ram_data_o      RAM write data   (0 when not writing)
//   ram_feedback_o  one-cycle pulse after the final word of the layer
//   busy_o          high while draining a pixel
//   overflow_o      sticky: a sample arrived when it could not be accepted
// All outputs are registered.
// -----------------------------------------------------------------------------
module fire4_5_expand3_ofm_writer
    import fire_pkg::*;
#(
    parameter int  WIDTH  = FIRE45_WIDTH,
    parameter int  DSP_NO = FIRE45_DSP_NO,
    parameter int  WOUT   = FIRE45_WOUT,
    localparam int ADDR_W = calc_addr_w(WOUT, DSP_NO)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              sample_i,
    input  logic [WIDTH-1:0]  ofm_i [0:DSP_NO-1],
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [WIDTH-1:0]  ram_data_o,
    output logic              ram_feedback_o,
    output logic              busy_o,
    output logic              overflow_o
);

    localparam int NPIX  = WOUT * WOUT;
    localparam int CH_W  = $clog2(DSP_NO);
    // One extra bit so the pixel counter can reach NPIX itself
    localparam int PIX_W = $clog2(NPIX) + 1;

    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(DSP_NO - 1);
    localparam logic [PIX_W-1:0] PIX_TOTAL = PIX_W'(NPIX);

    wr_state_e         state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [PIX_W-1:0]  pix_inc_s;
    logic              ovf_q, ovf_d;
    logic              load_s;
    logic [WIDTH-1:0]  rd_data_s;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              fb_q, fb_d;
    logic              busy_q, busy_d;

    ofm_capture_buf #(
        .WIDTH  (WIDTH),
        .DSP_NO (DSP_NO)
    ) u_buf (
        .clk       (clk),
        .load_i    (load_s),
        .data_i    (ofm_i),
        .rd_idx_i  (ch_d),
        .rd_data_o (rd_data_s)
    );

    // Next-state, counter and overflow logic
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        pix_d     = pix_q;
        ovf_d     = ovf_q;
        fb_d      = 1'b0;
        load_s    = 1'b0;
        pix_inc_s = pix_q + PIX_W'(1);

        if (start_i) begin
            // Abort everything; a coincident sample is dropped silently
            state_d = ST_IDLE;
            ch_d    = {CH_W{1'b0}};
            pix_d   = {PIX_W{1'b0}};
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sample_i) begin
                        load_s  = 1'b1;
                        state_d = ST_DRAIN;
                        ch_d    = {CH_W{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (ch_q == CH_LAST) begin
                        ch_d  = {CH_W{1'b0}};
                        pix_d = pix_inc_s;
                        if (pix_inc_s == PIX_TOTAL) begin
                            // Layer complete: nothing more can be accepted
                            state_d = ST_DONE;
                            fb_d    = 1'b1;
                            ovf_d   = ovf_q | sample_i;
                        end else if (sample_i) begin
                            // Back-to-back pixel: reload and keep draining
                            load_s  = 1'b1;
                            state_d = ST_DRAIN;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        ch_d  = ch_q + CH_W'(1);
                        ovf_d = ovf_q | sample_i;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                    ovf_d   = ovf_q | sample_i;
                end
                default: begin
                    state_d = ST_IDLE;
                    ch_d    = {CH_W{1'b0}};
                    pix_d   = {PIX_W{1'b0}};
                end
            endcase
        end
    end

    // Output register inputs: describe the word written in the next cycle.
    // On a fresh capture the buffer is not loaded yet, so channel 0 comes
    // straight from ofm_i to keep the first write one cycle after the strobe.
    always_comb begin
        we_d   = (state_d == ST_DRAIN);
        busy_d = (state_d == ST_DRAIN);
        if (we_d) begin
            addr_d = ADDR_W'(pix_d) * ADDR_W'(DSP_NO) + ADDR_W'(ch_d);
            data_d = load_s ? ofm_i[0] : rd_data_s;
        end else begin
            addr_d = {ADDR_W{1'b0}};
            data_d = {WIDTH{1'b0}};
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ch_q    <= {CH_W{1'b0}};
            pix_q   <= {PIX_W{1'b0}};
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            data_q  <= {WIDTH{1'b0}};
            fb_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            pix_q   <= pix_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            fb_q    <= fb_d;
            busy_q  <= busy_d;
        end
    end

    assign ram_we_o       = we_q;
    assign ram_addr_o     = addr_q;
    assign ram_data_o     = data_q;
    assign ram_feedback_o = fb_q;
    assign busy_o         = busy_q;
    assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_fire4_5_expand3_ofm_writer.sv
// -----------------------------------------------------------------------------
// Bench for fire4_5_expand3_ofm_writer. The map side is reduced to 4 so that a
// whole layer (16 pixels x 128 channels) fits in a short run. The reference
// model is a timeline: every accepted sample schedules its 128 writes at
// absolute cycle numbers; start/reset cancels writes scheduled later.
// -----------------------------------------------------------------------------
module tb_fire4_5_expand3_ofm_writer;

    localparam int WIDTH  = 16;
    localparam int DSP    = 128;
    localparam int WOUT   = 4;
    localparam int NPIX   = WOUT * WOUT;
    localparam int NWORDS = NPIX * DSP;
    localparam int AW     = $clog2(NWORDS);

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic              sample_i;
    logic [WIDTH-1:0]  ofm_i [0:DSP-1];
    logic              ram_we_o;
    logic [AW-1:0]     ram_addr_o;
    logic [WIDTH-1:0]  ram_data_o;
    logic              ram_feedback_o;
    logic              busy_o;
    logic              overflow_o;

    fire4_5_expand3_ofm_writer #(
        .WIDTH  (WIDTH),
        .DSP_NO (DSP),
        .WOUT   (WOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .sample_i       (sample_i),
        .ofm_i          (ofm_i),
        .ram_we_o       (ram_we_o),
        .ram_addr_o     (ram_addr_o),
        .ram_data_o     (ram_data_o),
        .ram_feedback_o (ram_feedback_o),
        .busy_o         (busy_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;      // period whose inputs are currently being driven
    wr_t  exp_q[$];       // scheduled writes, ordered by cycle
    int   n_pix   = 0;    // pixels accepted since the last start/reset
    int   done_at = -1;   // cycle of the feedback pulse / first DONE cycle
    bit   m_ovf   = 1'b0;
    bit   use_ramp = 1'b0;
    bit   track    = 1'b0;
    bit   seen [NWORDS];
    logic [WIDTH-1:0] vec [DSP];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, expv, cyc);
        end
    endtask

    // Apply the rules to the inputs sampled at the end of period c
    task automatic model_edge(input int c, input bit st, input bit smp, input bit r);
        if (!r || st) begin
            while (exp_q.size() > 0 && exp_q[$].cyc > c) void'(exp_q.pop_back());
            n_pix   = 0;
            done_at = -1;
            m_ovf   = 1'b0;
        end else if (smp) begin
            if (done_at >= 0 && c >= done_at) begin
                m_ovf = 1'b1;                       // layer already finished
            end else if (exp_q.size() > 0 && exp_q[$].cyc > c) begin
                m_ovf = 1'b1;                       // collides with a drain
            end else if (n_pix == NPIX) begin
                m_ovf = 1'b1;                       // last write of the layer
            end else begin
                for (int k = 0; k < DSP; k++)
                    exp_q.push_back('{c + 1 + k, n_pix * DSP + k, int'(vec[k])});
                n_pix++;
                if (n_pix == NPIX) done_at = c + DSP + 1;
            end
        end
    endtask

    task automatic check_period(input int p);
        int ew;
        int ea;
        int ed;
        wr_t e;
        ew = 0; ea = 0; ed = 0;
        if (exp_q.size() > 0 && exp_q[0].cyc == p) begin
            e  = exp_q.pop_front();
            ew = 1; ea = e.addr; ed = e.data;
        end
        chk("we",       32'(ram_we_o),       32'(ew));
        chk("addr",     32'(ram_addr_o),     32'(ea));
        chk("data",     32'(ram_data_o),     32'(ed));
        chk("busy",     32'(busy_o),         32'(ew));
        chk("feedback", 32'(ram_feedback_o), 32'(done_at == p));
        chk("overflow", 32'(overflow_o),     32'(m_ovf));
        if (track && ram_we_o === 1'b1 && !$isunknown(ram_addr_o)) begin
            chk("addr_once", 32'(seen[ram_addr_o]), 32'd0);
            seen[ram_addr_o] = 1'b1;
        end
    endtask

    task automatic step(input bit st, input bit smp, input bit r);
        rst      = r;
        start_i  = st;
        sample_i = smp;
        if (smp) begin
            for (int k = 0; k < DSP; k++) begin
                ofm_i[k] = use_ramp ? WIDTH'(k + 16'h100) : WIDTH'($urandom);
                vec[k]   = ofm_i[k];
            end
        end
        @(posedge clk);
        model_edge(cyc, st, smp, r);
        cyc++;
        #1;
        check_period(cyc);
        rst      = 1'b1;
        start_i  = 1'b0;
        sample_i = 1'b0;
    endtask

    initial begin
        int nseen;
        int gap;
        rst = 1'b0; start_i = 1'b0; sample_i = 1'b0;
        for (int k = 0; k < DSP; k++) ofm_i[k] = '0;

        // Reset for two cycles, then start the layer
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1);

        // Single sample with a ramp pattern: addr 0..127, data 0x100..0x17F
        use_ramp = 1'b1;
        step(1'b0, 1'b1, 1'b1);
        use_ramp = 1'b0;
        repeat (135) step(1'b0, 1'b0, 1'b1);

        // Back-to-back: second strobe in the cycle of the channel-127 write
        step(1'b0, 1'b1, 1'b1);
        repeat (127) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        repeat (135) step(1'b0, 1'b0, 1'b1);

        // Collision at t+50: dropped, overflow set, data unchanged
        step(1'b0, 1'b1, 1'b1);
        repeat (49) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        repeat (100) step(1'b0, 1'b0, 1'b1);

        // Pixel 4, then abort on the 60th write of pixel 5
        step(1'b0, 1'b1, 1'b1);
        repeat (135) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        repeat (59) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        repeat (135) step(1'b0, 1'b0, 1'b1);

        // Reset in the middle of a drain, then resume from address 0
        step(1'b0, 1'b1, 1'b1);
        repeat (30) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        repeat (135) step(1'b0, 1'b0, 1'b1);

        // Full layer, mixing back-to-back and spaced strobes
        step(1'b1, 1'b0, 1'b1);
        for (int a = 0; a < NWORDS; a++) seen[a] = 1'b0;
        track = 1'b1;
        for (int p = 0; p < NPIX; p++) begin
            step(1'b0, 1'b1, 1'b1);
            gap = (p % 4 == 0) ? 127 : 127 + int'($urandom_range(1, 20));
            repeat (gap) step(1'b0, 1'b0, 1'b1);
        end
        repeat (5) step(1'b0, 1'b0, 1'b1);
        // A sample in DONE writes nothing and sets overflow
        step(1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        track = 1'b0;
        nseen = 0;
        for (int a = 0; a < NWORDS; a++) nseen += int'(seen[a]);
        chk("all_addr_written", 32'(nseen), 32'(NWORDS));

        // Leave DONE, then random strobes/starts/resets
        step(1'b1, 1'b0, 1'b1);
        repeat (3000) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 499) != 0);
        end
        repeat (140) step(1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
